// File: rtl/stack_game_pkg.sv
// Shared definitions for the stacking game: state encoding and default tuning constants
// used by the level sequencer, block-motion and overlay logic.
package stack_game_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    PAUSE = 3'd2,
    OVER  = 3'd3,
    CLEAR = 3'd4
  } game_state_t;

  localparam int DEF_MAX_LEVEL        = 9;
  localparam int DEF_STACKS_PER_LEVEL = 8;
  localparam int DEF_PAUSE_FRAMES     = 60;
  localparam int DEF_HOLD_FRAMES      = 120;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/frame_down_counter.sv
// Loadable frame-tick down counter that saturates at zero; shared by the
// between-level pause and the game-over/clear start lockout.
module frame_down_counter #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/level_seq_ctrl.sv
// Game-flow sequencer: counts placements, advances levels with a timed pause,
// and drives the overlay level digit / status flags plus the gameplay enable.
module level_seq_ctrl
  import stack_game_pkg::*;
#(
  parameter int MAX_LEVEL        = DEF_MAX_LEVEL,
  parameter int STACKS_PER_LEVEL = DEF_STACKS_PER_LEVEL,
  parameter int PAUSE_FRAMES     = DEF_PAUSE_FRAMES,
  parameter int HOLD_FRAMES      = DEF_HOLD_FRAMES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       start,
  input  logic       place_ok,
  input  logic       place_miss,
  output logic [3:0] leveldig,
  output logic [3:0] stack_cnt,
  output logic       play_en,
  output logic       game_over,
  output logic       game_clear,
  output logic       level_up
);

  localparam int CW = $clog2(max_int(PAUSE_FRAMES, HOLD_FRAMES) + 1);

  localparam logic [3:0]    LAST_STACK = 4'(STACKS_PER_LEVEL - 1);
  localparam logic [3:0]    FULL_STACK = 4'(STACKS_PER_LEVEL);
  localparam logic [3:0]    TOP_LEVEL  = 4'(MAX_LEVEL);
  localparam logic [CW-1:0] PAUSE_LD   = CW'(PAUSE_FRAMES);
  localparam logic [CW-1:0] HOLD_LD    = CW'(HOLD_FRAMES);

  game_state_t state_q, state_d;
  logic [3:0]  leveldig_q, leveldig_d;
  logic [3:0]  stack_cnt_q, stack_cnt_d;
  logic        play_en_q, play_en_d;
  logic        game_over_q, game_over_d;
  logic        game_clear_q, game_clear_d;
  logic        level_up_q, level_up_d;

  logic          cnt_load;
  logic [CW-1:0] cnt_load_val;
  logic          cnt_dec;
  logic [CW-1:0] cnt;
  logic          cnt_zero;

  frame_down_counter #(.W(CW)) u_frame_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      leveldig_q   <= 4'd1;
      stack_cnt_q  <= 4'd0;
      play_en_q    <= 1'b0;
      game_over_q  <= 1'b0;
      game_clear_q <= 1'b0;
      level_up_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      leveldig_q   <= leveldig_d;
      stack_cnt_q  <= stack_cnt_d;
      play_en_q    <= play_en_d;
      game_over_q  <= game_over_d;
      game_clear_q <= game_clear_d;
      level_up_q   <= level_up_d;
    end
  end

  // A miss always wins over a simultaneous successful placement.
  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = PLAY;
      end
      PLAY: begin
        if (place_miss) begin
          state_d      = OVER;
          cnt_load     = 1'b1;
          cnt_load_val = HOLD_LD;
        end else if (place_ok && (stack_cnt_q == LAST_STACK)) begin
          cnt_load = 1'b1;
          if (leveldig_q == TOP_LEVEL) begin
            state_d      = CLEAR;
            cnt_load_val = HOLD_LD;
          end else begin
            state_d      = PAUSE;
            cnt_load_val = PAUSE_LD;
          end
        end
      end
      PAUSE: begin
        cnt_dec = tick;
        if (tick && (cnt == CW'(1))) state_d = PLAY;
      end
      OVER, CLEAR: begin
        cnt_dec = tick;
        if (start && cnt_zero) state_d = PLAY;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    leveldig_d   = leveldig_q;
    stack_cnt_d  = stack_cnt_q;
    level_up_d   = 1'b0;
    play_en_d    = (state_d == PLAY);
    game_over_d  = (state_d == OVER);
    game_clear_d = (state_d == CLEAR);
    if ((state_d == PLAY) && (state_q != PLAY) && (state_q != PAUSE)) begin
      leveldig_d  = 4'd1;
      stack_cnt_d = 4'd0;
    end else if ((state_q == PLAY) && place_ok && !place_miss) begin
      if (stack_cnt_q != LAST_STACK) begin
        stack_cnt_d = stack_cnt_q + 4'd1;
      end else if (state_d == CLEAR) begin
        stack_cnt_d = FULL_STACK;
      end else begin
        leveldig_d  = leveldig_q + 4'd1;
        stack_cnt_d = 4'd0;
        level_up_d  = 1'b1;
      end
    end
  end

  assign leveldig   = leveldig_q;
  assign stack_cnt  = stack_cnt_q;
  assign play_en    = play_en_q;
  assign game_over  = game_over_q;
  assign game_clear = game_clear_q;
  assign level_up   = level_up_q;

endmodule

// File: tb/tb_level_seq_ctrl.sv
// Directed bench: a default-parameter instance (a_) and a MAX_LEVEL=2 instance (b_)
// share stimulus; expected values are hand-derived constants.
module tb_level_seq_ctrl;

  logic clk = 1'b0;
  logic reset_n, tick, start, place_ok, place_miss;

  logic [3:0] a_leveldig, a_stack_cnt, b_leveldig, b_stack_cnt;
  logic a_play_en, a_game_over, a_game_clear, a_level_up;
  logic b_play_en, b_game_over, b_game_clear, b_level_up;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  level_seq_ctrl dut_a (
    .clk(clk), .reset_n(reset_n), .tick(tick), .start(start),
    .place_ok(place_ok), .place_miss(place_miss),
    .leveldig(a_leveldig), .stack_cnt(a_stack_cnt), .play_en(a_play_en),
    .game_over(a_game_over), .game_clear(a_game_clear), .level_up(a_level_up)
  );

  level_seq_ctrl #(.MAX_LEVEL(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .tick(tick), .start(start),
    .place_ok(place_ok), .place_miss(place_miss),
    .leveldig(b_leveldig), .stack_cnt(b_stack_cnt), .play_en(b_play_en),
    .game_over(b_game_over), .game_clear(b_game_clear), .level_up(b_level_up)
  );

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // Drive one cycle of pulses, then sample 1ns after the edge.
  task automatic step(input logic s, input logic ok, input logic miss, input logic tk);
    start = s; place_ok = ok; place_miss = miss; tick = tk;
    @(posedge clk);
    #1;
    start = 1'b0; place_ok = 1'b0; place_miss = 1'b0; tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic oks(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; tick = 1'b0; start = 1'b0; place_ok = 1'b0; place_miss = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;

    chk_eq("rst_leveldig", a_leveldig, 1);
    chk_eq("rst_stack", a_stack_cnt, 0);
    chk_eq("rst_flags", {a_play_en, a_game_over, a_game_clear, a_level_up}, 0);

    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk_eq("idle_miss_ignored", {a_play_en, a_game_over, a_game_clear}, 0);

    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk_eq("start_play_en", a_play_en, 1);
    chk_eq("start_leveldig", a_leveldig, 1);
    chk_eq("start_over_clear", {a_game_over, a_game_clear}, 0);

    oks(3);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk_eq("play_start_ignored_stack", a_stack_cnt, 3);
    chk_eq("play_start_ignored_en", a_play_en, 1);

    oks(4);
    chk_eq("stack_7", a_stack_cnt, 7);
    chk_eq("l1_no_levelup_yet", a_level_up, 0);
    oks(1);
    chk_eq("adv_level_up", a_level_up, 1);
    chk_eq("adv_leveldig", a_leveldig, 2);
    chk_eq("adv_play_en", a_play_en, 0);
    chk_eq("adv_stack", a_stack_cnt, 0);
    chk_eq("b_adv_leveldig", b_leveldig, 2);

    oks(1);
    chk_eq("levelup_one_cycle", a_level_up, 0);
    chk_eq("pause_ok_ignored_stack", a_stack_cnt, 0);
    chk_eq("pause_ok_ignored_lvl", a_leveldig, 2);

    ticks(59);
    chk_eq("pause_59_play_en", a_play_en, 0);
    ticks(1);
    chk_eq("pause_60_play_en", a_play_en, 1);
    chk_eq("b_pause_60_play_en", b_play_en, 1);

    oks(8);
    chk_eq("a_l3_leveldig", a_leveldig, 3);
    chk_eq("b_clear_flag", b_game_clear, 1);
    chk_eq("b_clear_leveldig", b_leveldig, 2);
    chk_eq("b_clear_stack", b_stack_cnt, 8);
    chk_eq("b_clear_no_levelup", b_level_up, 0);
    chk_eq("b_clear_play_en", b_play_en, 0);

    ticks(119);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk_eq("b_clear_start_locked", b_game_clear, 1);
    chk_eq("b_clear_locked_play_en", b_play_en, 0);
    ticks(1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk_eq("b_clear_restart_en", b_play_en, 1);
    chk_eq("b_clear_restart_lvl", b_leveldig, 1);
    chk_eq("b_clear_restart_flag", b_game_clear, 0);
    chk_eq("a_play_after_pause", a_play_en, 1);
    chk_eq("a_l3_kept", a_leveldig, 3);

    oks(7);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk_eq("miss_prio_over", a_game_over, 1);
    chk_eq("miss_prio_lvl", a_leveldig, 3);
    chk_eq("miss_prio_levelup", a_level_up, 0);
    chk_eq("miss_prio_play_en", a_play_en, 0);
    chk_eq("b_miss_prio_over", b_game_over, 1);

    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk_eq("over_start_locked", a_game_over, 1);
    ticks(120);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk_eq("over_restart_en", a_play_en, 1);
    chk_eq("over_restart_lvl", a_leveldig, 1);
    chk_eq("over_restart_flag", a_game_over, 0);

    oks(8);
    ticks(60);
    oks(8);
    chk_eq("a_pause_l3_lvl", a_leveldig, 3);
    chk_eq("a_pause_l3_en", a_play_en, 0);
    reset_n = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    chk_eq("midrst_lvl", a_leveldig, 1);
    chk_eq("midrst_stack", a_stack_cnt, 0);
    chk_eq("midrst_flags", {a_play_en, a_game_over, a_game_clear, a_level_up}, 0);
    chk_eq("b_midrst_flags", {b_play_en, b_game_over, b_game_clear, b_level_up}, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk_eq("midrst_idle_holds", a_play_en, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
